unified_mem_arbiter: RTL and testbench

// Shares one single-port unified memory between instruction fetch (IF port) and load/store (DM port).
// One transaction is outstanding at a time. DM has fixed priority, bounded by an anti-starvation counter
// so fetch still makes progress. Responses are routed back to the granted port.

---
 rtl/unified_mem_arbiter_if.sv | 51 +++++
 rtl/unified_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of the unified memory arbiter.
// master: arbiter view; slave: view of the surrounding requesters and memory.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_flush;
  logic                  if_rsp_valid;
  logic [DATA_WIDTH-1:0] if_rsp_rdata;

  logic                  dm_req_valid;
  logic                  dm_req_ready;
  logic [ADDR_WIDTH-1:0] dm_req_addr;
  logic                  dm_req_we;
  logic [DATA_WIDTH-1:0] dm_req_wdata;
  logic [BE_WIDTH-1:0]   dm_req_be;
  logic                  dm_rsp_valid;
  logic [DATA_WIDTH-1:0] dm_rsp_rdata;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_we;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [BE_WIDTH-1:0]   mem_req_be;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_rdata;

  modport master (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_rsp_valid, if_rsp_rdata,
    input  dm_req_valid, dm_req_addr, dm_req_we, dm_req_wdata, dm_req_be,
    output dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata,
    output dm_req_valid, dm_req_addr, dm_req_we, dm_req_wdata, dm_req_be,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction
// at a time; load/store has priority, capped by a streak counter so fetch keeps moving.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  unified_mem_arbiter_if.master bus,
  output logic                  busy
);
  localparam int unsigned BE_WIDTH     = DATA_WIDTH / 8;
  localparam int unsigned STREAK_WIDTH = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                  state_q, state_d;
  logic                    owner_dm_q, owner_dm_d;
  logic                    drop_q, drop_d;
  logic [STREAK_WIDTH-1:0] streak_q, streak_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    if_rsp_q, if_rsp_d;
  logic                    dm_rsp_q, dm_rsp_d;
  logic                    if_grant, dm_grant;

  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    drop_d     = drop_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    if_rsp_d   = 1'b0;
    dm_rsp_d   = 1'b0;
    if_grant   = 1'b0;
    dm_grant   = 1'b0;

    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (bus.if_req_valid && (!bus.dm_req_valid || streak_q == STREAK_MAX)) begin
          if_grant = 1'b1;
        end else if (bus.dm_req_valid) begin
          dm_grant = 1'b1;
        end

        if (if_grant) begin
          owner_dm_d = 1'b0;
          addr_d     = bus.if_req_addr;
          we_d       = 1'b0;
          wdata_d    = '0;
          be_d       = '1;
          streak_d   = '0;
          state_d    = StIssue;
        end else if (dm_grant) begin
          owner_dm_d = 1'b1;
          addr_d     = bus.dm_req_addr;
          we_d       = bus.dm_req_we;
          wdata_d    = bus.dm_req_wdata;
          be_d       = bus.dm_req_be;
          // Only a waiting fetch makes a data grant count towards the streak.
          if (!bus.if_req_valid) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_WIDTH'(1);
          end
          state_d = StIssue;
        end
      end

      StIssue: begin
        if (bus.if_flush && !owner_dm_q) drop_d = 1'b1;
        if (bus.mem_req_ready) state_d = StWait;
      end

      StWait: begin
        if (bus.if_flush && !owner_dm_q) drop_d = 1'b1;
        if (bus.mem_rsp_valid) begin
          rdata_d  = (owner_dm_q && we_q) ? '0 : bus.mem_rsp_rdata;
          if_rsp_d = !owner_dm_q && !drop_q && !bus.if_flush;
          dm_rsp_d = owner_dm_q;
          drop_d   = 1'b0;
          state_d  = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      owner_dm_q <= 1'b0;
      drop_q     <= 1'b0;
      streak_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      if_rsp_q   <= 1'b0;
      dm_rsp_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      drop_q     <= drop_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      if_rsp_q   <= if_rsp_d;
      dm_rsp_q   <= dm_rsp_d;
    end
  end

  assign bus.if_req_ready  = if_grant;
  assign bus.dm_req_ready  = dm_grant;
  assign bus.if_rsp_valid  = if_rsp_q;
  assign bus.if_rsp_rdata  = if_rsp_q ? rdata_q : '0;
  assign bus.dm_rsp_valid  = dm_rsp_q;
  assign bus.dm_rsp_rdata  = dm_rsp_q ? rdata_q : '0;
  assign bus.mem_req_valid = (state_q == StIssue);
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_be    = be_q;
  assign busy              = (state_q != StIdle);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, memory requests and responses;
// a memory model and a response monitor compare what the arbiter actually does.
module tb_unified_mem_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = DW / 8;
  localparam int          MAXS = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } mreq_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] mac_mem [256];
  mreq_t exp_mem_q [$];
  rsp_t  if_exp_q [$];
  rsp_t  dm_exp_q [$];

  // memory model knobs
  int ready_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  bit hold = 1'b0;
  int stall_left = 0;

  // transaction-level model state
  bit            m_busy = 1'b0;
  bit            m_owner_dm = 1'b0;
  bit            m_drop = 1'b0;
  int            m_streak = 0;
  logic [DW-1:0] m_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  unified_mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < int'(BW); b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory macro: random ready, response 1..N cycles after acceptance.
  initial begin : mem_model
    bit            pend;
    bit            stall;
    bit            acc;
    int            cnt;
    int            idx;
    logic [DW-1:0] rd;
    mreq_t         prev;
    mreq_t         e;
    pend = 1'b0;
    stall = 1'b0;
    cnt = 0;
    rd = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      acc = arst_n && bus.mem_req_valid && bus.mem_req_ready;
      if (arst_n && stall) begin
        check("mem_req_valid_held", bus.mem_req_valid, 1);
        check("mem_req_addr_stable", bus.mem_req_addr, prev.addr);
        check("mem_req_we_stable", bus.mem_req_we, prev.we);
        check("mem_req_wdata_stable", bus.mem_req_wdata, prev.wdata);
        check("mem_req_be_stable", bus.mem_req_be, prev.be);
      end
      stall = arst_n && bus.mem_req_valid && !bus.mem_req_ready;
      if (stall) begin
        prev.addr = bus.mem_req_addr;
        prev.we = bus.mem_req_we;
        prev.wdata = bus.mem_req_wdata;
        prev.be = bus.mem_req_be;
      end
      if (acc) begin
        check("mem_req_expected", exp_mem_q.size() != 0, 1);
        if (exp_mem_q.size() != 0) begin
          e = exp_mem_q.pop_front();
          check("mem_req_addr", bus.mem_req_addr, e.addr);
          check("mem_req_we", bus.mem_req_we, e.we);
          check("mem_req_be", bus.mem_req_be, e.be);
          if (e.we) check("mem_req_wdata", bus.mem_req_wdata, e.wdata);
        end
        idx = int'(bus.mem_req_addr[9:2]);
        if (bus.mem_req_we) begin
          mac_mem[idx] = merge(mac_mem[idx], bus.mem_req_wdata, bus.mem_req_be);
          rd = $urandom;
        end else begin
          rd = mac_mem[idx];
        end
        pend = 1'b1;
        cnt = int'($urandom_range(lat_max, lat_min));
      end
      @(posedge clk);
      #1;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = $urandom;
      if (pend && !hold) begin
        cnt--;
        if (cnt == 0) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_rdata = rd;
          pend = 1'b0;
        end
      end
      if (stall_left > 0) begin
        bus.mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        bus.mem_req_ready = (int'($urandom_range(99)) < ready_pct);
      end
    end
  end

  // Reference model: arbitration rules and expected results, one transaction at a time.
  initial begin : ref_model
    bit gi;
    bit gd;
    int idx;
    rsp_t  r;
    mreq_t q;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_streak = 0;
        continue;
      end
      gi = !m_busy && bus.if_req_valid && (!bus.dm_req_valid || m_streak == MAXS);
      gd = !m_busy && bus.dm_req_valid && !gi;
      check("if_req_ready", bus.if_req_ready, gi);
      check("dm_req_ready", bus.dm_req_ready, gd);
      check("busy", busy, m_busy);
      if (m_busy) begin
        if (bus.if_flush && !m_owner_dm) m_drop = 1'b1;
        if (bus.mem_rsp_valid) begin
          r.data = m_data;
          r.due = cyc + 1;
          if (m_owner_dm) dm_exp_q.push_back(r);
          else if (!m_drop) if_exp_q.push_back(r);
          m_busy = 1'b0;
        end
      end else if (gi || gd) begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_owner_dm = gd;
        if (gi) begin
          q.addr = bus.if_req_addr;
          q.we = 1'b0;
          q.wdata = '0;
          q.be = '1;
          m_data = ref_mem[int'(bus.if_req_addr[9:2])];
          m_streak = 0;
        end else begin
          q.addr = bus.dm_req_addr;
          q.we = bus.dm_req_we;
          q.wdata = bus.dm_req_wdata;
          q.be = bus.dm_req_be;
          idx = int'(bus.dm_req_addr[9:2]);
          if (bus.dm_req_we) begin
            ref_mem[idx] = merge(ref_mem[idx], bus.dm_req_wdata, bus.dm_req_be);
            m_data = '0;
          end else begin
            m_data = ref_mem[idx];
          end
          if (!bus.if_req_valid) m_streak = 0;
          else if (m_streak < MAXS) m_streak++;
        end
        exp_mem_q.push_back(q);
      end
    end
  end

  initial begin : rsp_monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      if (bus.if_rsp_valid) begin
        check("if_rsp_expected", if_exp_q.size() != 0, 1);
        if (if_exp_q.size() != 0) begin
          r = if_exp_q.pop_front();
          check("if_rsp_rdata", bus.if_rsp_rdata, r.data);
          check("if_rsp_cycle", cyc, r.due);
        end
      end
      if (bus.dm_rsp_valid) begin
        check("dm_rsp_expected", dm_exp_q.size() != 0, 1);
        if (dm_exp_q.size() != 0) begin
          r = dm_exp_q.pop_front();
          check("dm_rsp_rdata", bus.dm_rsp_rdata, r.data);
          check("dm_rsp_cycle", cyc, r.due);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_zero(input string tag);
    check({tag, "_if_req_ready"}, bus.if_req_ready, 0);
    check({tag, "_if_rsp_valid"}, bus.if_rsp_valid, 0);
    check({tag, "_if_rsp_rdata"}, bus.if_rsp_rdata, 0);
    check({tag, "_dm_req_ready"}, bus.dm_req_ready, 0);
    check({tag, "_dm_rsp_valid"}, bus.dm_rsp_valid, 0);
    check({tag, "_dm_rsp_rdata"}, bus.dm_rsp_rdata, 0);
    check({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
    check({tag, "_mem_req_addr"}, bus.mem_req_addr, 0);
    check({tag, "_mem_req_we"}, bus.mem_req_we, 0);
    check({tag, "_mem_req_wdata"}, bus.mem_req_wdata, 0);
    check({tag, "_mem_req_be"}, bus.mem_req_be, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Waits for the chosen port's ready, then drops its valid after the edge.
  task automatic wait_grant(input bit dm, output int gcyc);
    bit got;
    got = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (dm ? bus.dm_req_ready : bus.if_req_ready) begin
        got = 1'b1;
        gcyc = cyc;
      end
    end
    check(dm ? "dm_grant_seen" : "if_grant_seen", got, 1);
    @(posedge clk);
    #1;
    if (dm) bus.dm_req_valid = 1'b0;
    else bus.if_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit dm, output int rcyc);
    bit got;
    got = 1'b0;
    rcyc = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (dm ? bus.dm_rsp_valid : bus.if_rsp_valid) begin
        got = 1'b1;
        rcyc = cyc;
      end
    end
    check(dm ? "dm_rsp_seen" : "if_rsp_seen", got, 1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    check("idle_reached", idle, 1);
    @(negedge clk);
  endtask

  initial begin : stim
    int g;
    int p;
    int n;
    int pulses;
    int stalls;
    int order [10];
    logic [DW-1:0] v;

    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      mac_mem[i] = v;
    end
    ref_mem[64] = 32'hDEAD_BEEF;
    mac_mem[64] = 32'hDEAD_BEEF;
    bus.if_req_valid = 1'b0;
    bus.if_req_addr = '0;
    bus.if_flush = 1'b0;
    bus.dm_req_valid = 1'b0;
    bus.dm_req_addr = '0;
    bus.dm_req_we = 1'b0;
    bus.dm_req_wdata = '0;
    bus.dm_req_be = '0;

    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    arst_n = 1'b1;

    // single fetch, 3-cycle latency
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr = 32'h100;
    wait_grant(1'b0, g);
    wait_rsp(1'b0, p);
    check("fetch_latency", p - g, 3);

    // contention: both valid continuously
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr = 32'h040;
    bus.dm_req_valid = 1'b1;
    bus.dm_req_addr = 32'h080;
    bus.dm_req_we = 1'b0;
    for (int i = 0; i < 10; i++) order[i] = -1;
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge clk);
      if (bus.dm_req_ready) order[n++] = 1;
      else if (bus.if_req_ready) order[n++] = 0;
    end
    for (int i = 0; i < 10; i++)
      check($sformatf("grant_order_%0d", i), order[i], (i % 5 == 4) ? 0 : 1);
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b0;
    bus.dm_req_valid = 1'b0;
    wait_idle();

    // store with partial byte enables
    @(posedge clk);
    #1;
    bus.dm_req_valid = 1'b1;
    bus.dm_req_addr = 32'h200;
    bus.dm_req_we = 1'b1;
    bus.dm_req_wdata = 32'h1234_5678;
    bus.dm_req_be = 4'h3;
    wait_grant(1'b1, g);
    wait_rsp(1'b1, p);
    check("store_latency", p - g, 3);

    // flush during WAIT suppresses the fetch response
    lat_min = 4;
    lat_max = 4;
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr = 32'h1F0;
    wait_grant(1'b0, g);
    @(posedge clk);
    #1;
    bus.if_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.if_flush = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.if_rsp_valid) pulses++;
    end
    check("flush_suppressed", pulses, 0);
    lat_min = 1;
    lat_max = 1;
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr = 32'h1F4;
    wait_grant(1'b0, g);
    wait_rsp(1'b0, p);
    check("post_flush_latency", p - g, 3);

    // backpressure: memory not ready for 5 cycles while a fetch waits
    @(posedge clk);
    #1;
    bus.dm_req_valid = 1'b1;
    bus.dm_req_addr = 32'h300;
    bus.dm_req_we = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n == 0; i++) begin
      @(negedge clk);
      if (bus.dm_req_ready) n = 1;
    end
    check("bp_dm_grant_seen", n, 1);
    stall_left = 5;
    @(posedge clk);
    #1;
    bus.dm_req_valid = 1'b0;
    bus.if_req_valid = 1'b1;
    bus.if_req_addr = 32'h304;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req_valid && !bus.mem_req_ready) stalls++;
      if (bus.mem_req_valid && bus.mem_req_ready) break;
    end
    check("bp_stall_cycles", stalls, 5);
    wait_grant(1'b0, g);
    wait_rsp(1'b0, p);

    // reset while a store waits for its response; the late response must be ignored
    hold = 1'b1;
    @(posedge clk);
    #1;
    bus.dm_req_valid = 1'b1;
    bus.dm_req_addr = 32'h3F0;
    bus.dm_req_we = 1'b1;
    bus.dm_req_wdata = 32'hA5A5_5A5A;
    bus.dm_req_be = 4'hF;
    wait_grant(1'b1, g);
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_wait");
    hold = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.if_rsp_valid || bus.dm_rsp_valid) pulses++;
    end
    check("stale_rsp_ignored", pulses, 0);

    // randomized traffic
    ready_pct = 70;
    lat_min = 1;
    lat_max = 3;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      bus.if_req_valid = (int'($urandom_range(99)) < 60);
      bus.if_req_addr = AW'($urandom_range(255)) << 2;
      bus.if_flush = (int'($urandom_range(99)) < 10);
      bus.dm_req_valid = (int'($urandom_range(99)) < 50);
      bus.dm_req_addr = AW'($urandom_range(255)) << 2;
      bus.dm_req_we = 1'($urandom_range(1));
      bus.dm_req_wdata = $urandom;
      bus.dm_req_be = BW'($urandom_range(15));
    end
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b0;
    bus.dm_req_valid = 1'b0;
    bus.if_flush = 1'b0;
    ready_pct = 100;
    wait_idle();
    repeat (3) @(negedge clk);
    check("if_queue_drained", if_exp_q.size(), 0);
    check("dm_queue_drained", dm_exp_q.size(), 0);
    check("mem_queue_drained", exp_mem_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
